fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of `instruction_memory`. It owns the program counter and drives the memory's 8-bit address. It registers the 15-bit instruction returned and presents it to the decode stage over a valid/ready handshake. It supports jumps with a pipeline flush, halt, and wrap-around at the end of program memory.

## Interface
- `ADDR_W`, default 8: program counter and memory address width.
- `INSTR_W`, default 15: instruction width.
- `MEM_DEPTH`, default 15: number of valid instruction words, addresses 0..MEM_DEPTH-1.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_addr`, output, ADDR_W: address to `instruction_memory`; equals the PC register (combinational).
- `imem_data`, input, INSTR_W: instruction read combinationally from `instruction_memory`.
- `instr`, output, INSTR_W: registered instruction to decode.
- `instr_pc`, output, ADDR_W: address that `instr` was fetched from.
- `instr_valid`, output, 1: `instr` and `instr_pc` are meaningful.
- `instr_ready`, input, 1: decode accepts `instr` this cycle.
- `jump_en`, input, 1: redirect fetch to `jump_addr`.
- `jump_addr`, input, ADDR_W: jump target.
- `halt`, input, 1: stop fetching.
- `halted`, output, 1: high while in HALT.

## Operation
- States: IDLE, RUN, HALT.
- On reset: state = IDLE, `pc` = RESET_PC, `instr` = 0, `instr_pc` = 0, `instr_valid` = 0, `halted` = 0.
- IDLE always moves to RUN on the next edge; no fetch happens in IDLE.
- A slot is free when `!instr_valid || instr_ready`.
- RUN with a free slot and no jump or halt:
  - `instr` <= `imem_data`, `instr_pc` <= `pc`, `instr_valid` <= 1.
  - `pc` <= `pc_next`, where `pc_next` = 0 if `pc` == MEM_DEPTH-1, else `pc`+1.
- RUN with no free slot: `pc`, `instr`, `instr_pc` and `instr_valid` all hold. Outputs must stay stable while `instr_valid && !instr_ready`.
- Jump (RUN or HALT, `jump_en`=1, `halt`=0):
  - `pc` <= `jump_addr`, or 0 if `jump_addr` >= MEM_DEPTH.
  - `instr_valid` <= 0 (flush), regardless of `instr_ready`.
  - State becomes RUN.
- Halt (RUN, `halt`=1): state <= HALT and `halted` <= 1; no capture that edge. `halt` has priority over a simultaneous `jump_en`.
- In HALT:
  - No fetch, and `pc` holds.
  - An already-valid instruction stays presented until accepted, then `instr_valid` <= 0.
  - `jump_en` leaves HALT and clears `halted`; `halt` and `jump_en` both high keeps HALT.
  - Reset also leaves HALT.
- Asserting reset mid-operation immediately forces all reset values. Any in-flight instruction is lost.

## Timing
- `imem_addr` follows `pc` with zero latency. The memory read is combinational, so capture happens the same cycle.
- Fetch latency is 1 cycle: `pc`=A in RUN gives `instr`=mem[A] with `instr_valid`=1 on the next edge.
- After `rst_n` rises:
  - Edge 1 enters RUN.
  - Edge 2 presents mem[RESET_PC].
- Sustained throughput is 1 instruction per cycle while `instr_ready`=1.
- Jump penalty is 1 bubble: the edge that takes the jump clears valid, and mem[target] appears on the following edge.
- `halted` rises on the edge that samples `halt`=1.

## Structure
- Shared package `fetch_pkg` holds:
  - The state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2).
  - Default widths ADDR_W, INSTR_W, MEM_DEPTH.
  - RESET_PC.
- One natural sub-module, `program_counter`: the PC register, wrap logic, jump-target clamping, and load/advance/hold controls.
- `fetch_unit` itself holds the FSM and the output register.

## Test plan
- Reset and stream: memory model loaded with 0x0020, 0x0021, 0x0022, 0x0023, then 0x0003 for the rest; `instr_ready`=1 throughout -> `instr` = 0x0020 (pc 0) on edge 2 after reset release, then 0x0021, 0x0022, 0x0023, 0x0003 on consecutive edges.
- Wrap-around: run 16 accepted fetches from reset -> `instr_pc` sequence 0..14 then 0, with `instr` = 0x0020 on the 16th fetch.
- Backpressure: drop `instr_ready` for 3 cycles while `instr`=0x0021 -> `instr`, `instr_pc`=1 and `imem_addr`=2 stable for those 3 cycles; 0x0022 is presented one edge after ready returns.
- Jump flush: `jump_en`=1 with `jump_addr`=3 while `pc`=1 -> `instr_valid`=0 for 1 cycle, then `instr`=0x0023 with `instr_pc`=3; a separate run with `jump_addr`=20 -> `instr_pc`=0.
- Halt and resume:
  - `halt` while `instr_valid`=1 and `instr_ready`=0 -> `halted`=1, instruction held until ready, then `instr_valid`=0 and `pc` frozen.
  - Then `jump_en` with target 0 -> `halted`=0, and 0x0020 is presented 1 cycle later.
  - `halt` and `jump_en` together in RUN -> enters HALT.
- Mid-run reset: pull `rst_n` low between edges while `instr_valid`=1 -> `instr_valid`, `instr`, `instr_pc` and `halted` go to 0 and `imem_addr` goes to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and
// default geometry of the program memory.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_INSTR_W   = 15;
  localparam int DEF_MEM_DEPTH = 15;
  localparam int DEF_RESET_PC  = 0;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, decode and control signals.
// Handshake: decode consumes instr when instr_valid && instr_ready on a rising
// edge; while instr_valid && !instr_ready, instr and instr_pc are held stable.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;
  logic               halt;
  logic               halted;

  modport master (
    output imem_addr, instr, instr_pc, instr_valid, halted,
    input  imem_data, instr_ready, jump_en, jump_addr, halt
  );

  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid, halted,
    output imem_data, instr_ready, jump_en, jump_addr, halt
  );
endinterface

// File: rtl/program_counter.sv
// Program counter register with wrap at the end of program memory and
// clamping of out-of-range jump targets. Load has priority over advance.
module program_counter
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int RESET_PC  = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(MEM_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_target;

  assign w_pc_next = (r_pc == LAST_ADDR) ? '0 : r_pc + 1'b1;
  assign w_target  = (i_load_addr >= DEPTH_A) ? '0 : i_load_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (i_load) begin
      r_pc <= w_target;
    end else if (i_advance) begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory
// combinationally and presents one registered instruction to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int INSTR_W   = DEF_INSTR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int RESET_PC  = DEF_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
  output fetch_state_e o_state
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_valid;
  logic [ADDR_W-1:0]  w_pc;
  logic               w_slot_free;
  logic               w_capture;
  logic               w_clear;
  logic               w_pc_load;
  logic               w_pc_adv;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_pc_load),
    .i_load_addr(bus.jump_addr),
    .i_advance  (w_pc_adv),
    .o_pc       (w_pc)
  );

  assign w_slot_free = !r_valid || bus.instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Halt outranks jump; a pending instruction drains while halting.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_adv     = 1'b0;
    unique case (r_state)
      ST_IDLE: w_state_next = ST_RUN;
      ST_RUN: begin
        if (bus.halt) begin
          w_state_next = ST_HALT;
          w_clear      = r_valid && bus.instr_ready;
        end else if (bus.jump_en) begin
          w_pc_load = 1'b1;
          w_clear   = 1'b1;
        end else if (w_slot_free) begin
          w_capture = 1'b1;
          w_pc_adv  = 1'b1;
        end
      end
      ST_HALT: begin
        if (bus.jump_en && !bus.halt) begin
          w_state_next = ST_RUN;
          w_pc_load    = 1'b1;
          w_clear      = 1'b1;
        end else if (bus.instr_ready) begin
          w_clear = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else if (w_clear) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr    <= bus.imem_data;
      r_instr_pc <= w_pc;
      r_valid    <= 1'b1;
    end
  end

  assign bus.imem_addr   = w_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = (r_state == ST_HALT);
  assign o_state         = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic         clk;
  logic         rst_n;
  fetch_state_e dut_state;
  logic [14:0]  mem [0:255];
  int           n_checks;
  int           n_pass;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .o_state(dut_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.imem_data = mem[bus.imem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.instr_ready = 1'b1;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = '0;
    bus.halt        = 1'b0;
  endtask

  // Leaves the bench 1ns after edge 2 following reset release: mem[0] presented.
  task automatic reset_and_start();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 15'h0003;
    mem[0] = 15'h0020;
    mem[1] = 15'h0021;
    mem[2] = 15'h0022;
    mem[3] = 15'h0023;

    // Reset state and stream
    drive_idle();
    rst_n = 1'b0;
    #12;
    check("rst_valid", bus.instr_valid, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_state", dut_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("edge1_state", dut_state, ST_RUN);
    check("edge1_valid", bus.instr_valid, 0);
    tick();
    check("edge2_valid", bus.instr_valid, 1);
    check("edge2_instr", bus.instr, 15'h0020);
    check("edge2_pc", bus.instr_pc, 0);
    tick(); check("stream1", bus.instr, 15'h0021);
    tick(); check("stream2", bus.instr, 15'h0022);
    tick(); check("stream3", bus.instr, 15'h0023);
    tick(); check("stream4", bus.instr, 15'h0003);
    check("stream4_pc", bus.instr_pc, 4);

    // Wrap-around over 16 accepted fetches
    reset_and_start();
    for (int i = 0; i < 16; i++) begin
      check("wrap_pc", bus.instr_pc, (i == 15) ? 0 : i);
      check("wrap_valid", bus.instr_valid, 1);
      if (i < 15) tick();
    end
    check("wrap_instr16", bus.instr, 15'h0020);

    // Backpressure for 3 cycles on 0x0021
    reset_and_start();
    tick();
    check("bp_instr", bus.instr, 15'h0021);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_instr", bus.instr, 15'h0021);
      check("bp_hold_pc", bus.instr_pc, 1);
      check("bp_hold_addr", bus.imem_addr, 2);
      check("bp_hold_valid", bus.instr_valid, 1);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("bp_resume", bus.instr, 15'h0022);

    // Jump flush, in-range and clamped targets
    reset_and_start();
    check("jmp_pre_addr", bus.imem_addr, 1);
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'd3;
    tick();
    bus.jump_en = 1'b0;
    check("jmp_bubble", bus.instr_valid, 0);
    check("jmp_addr", bus.imem_addr, 3);
    tick();
    check("jmp_instr", bus.instr, 15'h0023);
    check("jmp_pc", bus.instr_pc, 3);
    check("jmp_valid", bus.instr_valid, 1);
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'd20;
    tick();
    bus.jump_en = 1'b0;
    check("jmp20_bubble", bus.instr_valid, 0);
    check("jmp20_addr", bus.imem_addr, 0);
    tick();
    check("jmp20_pc", bus.instr_pc, 0);
    check("jmp20_instr", bus.instr, 15'h0020);

    // Halt with a stalled instruction, then resume via jump
    reset_and_start();
    bus.instr_ready = 1'b0;
    bus.halt        = 1'b1;
    tick();
    bus.halt = 1'b0;
    check("halt_halted", bus.halted, 1);
    check("halt_valid", bus.instr_valid, 1);
    check("halt_instr", bus.instr, 15'h0020);
    tick();
    check("halt_hold_valid", bus.instr_valid, 1);
    bus.instr_ready = 1'b1;
    tick();
    check("halt_drain_valid", bus.instr_valid, 0);
    check("halt_addr", bus.imem_addr, 1);
    tick();
    check("halt_frozen_addr", bus.imem_addr, 1);
    check("halt_still", bus.halted, 1);
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'd0;
    tick();
    bus.jump_en = 1'b0;
    check("resume_halted", bus.halted, 0);
    check("resume_bubble", bus.instr_valid, 0);
    tick();
    check("resume_instr", bus.instr, 15'h0020);
    check("resume_valid", bus.instr_valid, 1);
    bus.halt      = 1'b1;
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'd5;
    tick();
    check("hj_run_halted", bus.halted, 1);
    check("hj_run_addr", bus.imem_addr, 1);
    tick();
    check("hj_halt_stays", bus.halted, 1);
    check("hj_halt_addr", bus.imem_addr, 1);
    drive_idle();

    // Asynchronous reset mid-stream
    reset_and_start();
    tick();
    check("mid_pre_valid", bus.instr_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", bus.instr_valid, 0);
    check("mid_instr", bus.instr, 0);
    check("mid_instr_pc", bus.instr_pc, 0);
    check("mid_halted", bus.halted, 0);
    check("mid_addr", bus.imem_addr, 0);
    check("mid_state", dut_state, ST_IDLE);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
